// File: rtl/serial_frame_sync.sv
// serial_frame_sync: hunts a serial bit stream for a sync word, deserialises a
// fixed-length payload MSB-first into bytes and hands them out through a small
// FIFO on a valid/ready byte interface.
module serial_frame_sync #(
    parameter logic [7:0] SYNC_WORD   = 8'hA5,
    parameter int         FRAME_BYTES = 4,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       locked,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        ST_HUNT,
        ST_PAYLOAD
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  window_q, window_d;     // last 7 bits seen while hunting
    logic [3:0]  hunt_cnt_q, hunt_cnt_d; // saturates at 8
    logic [6:0]  shreg_q, shreg_d;       // partial payload byte
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;

    logic [7:0]  mem [FIFO_DEPTH];

    logic        accept;
    logic [7:0]  win_shifted;
    logic [7:0]  byte_shifted;
    logic        push;
    logic        pop;
    logic        wr_en;
    logic        fifo_empty;
    logic        fifo_full;

    // Next-state logic: sync hunting, payload deserialisation and FIFO bookkeeping.
    always_comb begin
        state_d      = state_q;
        window_d     = window_q;
        hunt_cnt_d   = hunt_cnt_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        overflow_d   = overflow_q;
        push         = 1'b0;

        accept       = ena & bit_valid;
        win_shifted  = {window_q, bit_in};
        byte_shifted = {shreg_q, bit_in};

        case (state_q)
            ST_HUNT: begin
                if (accept) begin
                    window_d = win_shifted[6:0];
                    if (hunt_cnt_q < 4'd8) begin
                        hunt_cnt_d = hunt_cnt_q + 4'd1;
                    end
                    // Needs 7 earlier bits plus this one since hunting began.
                    if (win_shifted == SYNC_WORD && hunt_cnt_q >= 4'd7) begin
                        state_d    = ST_PAYLOAD;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = 4'd0;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    shreg_d   = byte_shifted[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        push       = 1'b1;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        if (byte_cnt_q == 4'(FRAME_BYTES - 1)) begin
                            // Frame done: force a fresh 8-bit sync search.
                            state_d    = ST_HUNT;
                            window_d   = 7'd0;
                            hunt_cnt_d = 4'd0;
                            byte_cnt_d = 4'd0;
                        end
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase

        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = ~fifo_empty & out_ready & ena;
        // A pop in the same cycle frees the slot the push needs.
        wr_en      = push & (~fifo_full | pop);
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HUNT;
            window_q   <= 7'd0;
            hunt_cnt_q <= 4'd0;
            shreg_q    <= 7'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 4'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            window_q   <= window_d;
            hunt_cnt_q <= hunt_cnt_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= byte_shifted;
        end
    end

    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_empty ? 8'h00 : mem[rd_ptr_q[AW-1:0]];
    assign locked    = (state_q == ST_PAYLOAD);
    assign overflow  = overflow_q;

endmodule
